cv_ctrl_multi: RTL and testbench

CV_CTRL_MULTI -- requirements
Module: cv_ctrl_multi

---
 rtl/cv_ctrl_pkg.sv | 23 ++
 rtl/cv_ctrl_multi_if.sv | 12 +
 rtl/cv_quad_dec.sv | 36 +++
 rtl/cv_ctrl_multi.sv | 90 +++++++++
 tb/tb_cv_ctrl_multi.sv | 133 +++++++++++++
 5 files changed

// File: rtl/cv_ctrl_pkg.sv
// cv_ctrl_pkg: shared quadrature types, step classification and read-data bit positions
package cv_ctrl_pkg;
  typedef logic [1:0] quad_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL} step_e;
  localparam quad_t QUAD_RST = 2'b11;
  localparam int D_P1  = 0;
  localparam int D_P4  = 1;
  localparam int D_P2  = 2;
  localparam int D_P3  = 3;
  localparam int D_ONE = 4;
  localparam int D_P7  = 5;
  localparam int D_P6  = 6;
  localparam int D_DIR = 7;
  // Gray-coded {A,B} mapped to a position so the step is a mod-4 difference
  function automatic logic [1:0] quad_pos(quad_t q);
    return {q[1], q[1] ^ q[0]};
  endfunction
  function automatic step_e quad_step(quad_t from, quad_t to);
    logic [1:0] d;
    d = quad_pos(to) - quad_pos(from);
    return d == 2'd1 ? STEP_FWD : d == 2'd3 ? STEP_REV : d == 2'd2 ? STEP_ILL : STEP_NONE;
  endfunction
endpackage

// File: rtl/cv_ctrl_multi_if.sv
// cv_ctrl_multi_if: host read bus of the controller block (port select, read strobe, data, interrupt)
interface cv_ctrl_multi_if #(
  parameter int NUM_PORTS = 2
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  logic [PW-1:0] port_sel_i;
  logic          rd_i;
  logic [7:0]    d_o;
  logic          int_n_o;
  modport master (output port_sel_i, rd_i, input d_o, int_n_o);
  modport slave  (input port_sel_i, rd_i, output d_o, int_n_o);
endinterface

// File: rtl/cv_quad_dec.sv
// cv_quad_dec: filters synchronised A/B samples and classifies accepted transitions as steps
module cv_quad_dec
  import cv_ctrl_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic  clk_i,
  input  logic  reset_n_i,
  input  logic  en_i,
  input  logic  a_i,
  input  logic  b_i,
  output step_e step_o,
  output logic  dir_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  quad_t acc_q, cand_q, s;
  logic [CW-1:0] cnt_q, run;
  logic take;
  assign s = {a_i, b_i};
  assign run = (s == cand_q && cnt_q != '0) ? cnt_q + 1'b1 : CW'(1);
  assign take = en_i && s != acc_q && run >= CW'(FILT_LEN);
  assign step_o = take ? quad_step(acc_q, s) : STEP_NONE;
  // Illegal jumps still move the accepted state so the decoder resynchronises
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      acc_q  <= QUAD_RST;
      cand_q <= QUAD_RST;
      cnt_q  <= '0;
      dir_o  <= 1'b0;
    end else if (en_i) begin
      cand_q <= s;
      cnt_q  <= (s == acc_q || take) ? '0 : run;
      if (take) acc_q <= s;
      if (step_o == STEP_FWD || step_o == STEP_REV) dir_o <= step_o == STEP_FWD;
    end
endmodule

// File: rtl/cv_ctrl_multi.sv
// cv_ctrl_multi: multi-port controller interface with pin sync and read mux;
// spinner quadrature decoding and interrupt are built only when CV_CTRL_QUAD_EN is defined.
module cv_ctrl_multi
  import cv_ctrl_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clk_en_3m58_i,
  input  logic                 ctrl_en_key_n_i,
  input  logic                 ctrl_en_joy_n_i,
  input  logic [NUM_PORTS-1:0] ctrl_p1_i,
  input  logic [NUM_PORTS-1:0] ctrl_p2_i,
  input  logic [NUM_PORTS-1:0] ctrl_p3_i,
  input  logic [NUM_PORTS-1:0] ctrl_p4_i,
  input  logic [NUM_PORTS-1:0] ctrl_p6_i,
  input  logic [NUM_PORTS-1:0] ctrl_p7_i,
  input  logic [NUM_PORTS-1:0] ctrl_p9_i,
  output logic [NUM_PORTS-1:0] ctrl_p5_o,
  output logic [NUM_PORTS-1:0] ctrl_p8_o,
  cv_ctrl_multi_if.slave       bus
);
  logic [SYNC_STAGES-1:0][6:0][NUM_PORTS-1:0] sync_q;
  logic [6:0][NUM_PORTS-1:0] pins;
  logic [NUM_PORTS-1:0] s_p1, s_p2, s_p3, s_p4, s_p6, s_p7, s_p9, dir;
  logic sel_q, valid;
  logic [7:0] d;
  assign pins = {ctrl_p9_i, ctrl_p7_i, ctrl_p6_i, ctrl_p4_i, ctrl_p3_i, ctrl_p2_i, ctrl_p1_i};
  assign {s_p9, s_p7, s_p6, s_p4, s_p3, s_p2, s_p1} = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
  // Exactly one strobe low selects the mode; key strobe low means joystick select (0)
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) sel_q <= 1'b0;
    else if (clk_en_3m58_i && (ctrl_en_key_n_i ^ ctrl_en_joy_n_i)) sel_q <= ctrl_en_key_n_i;
  assign ctrl_p5_o = {NUM_PORTS{sel_q}};
  assign ctrl_p8_o = {NUM_PORTS{~sel_q}};
  assign valid = int'(bus.port_sel_i) < NUM_PORTS;
  always_comb begin
    d = 8'hFF;
    if (valid) begin
      d[D_DIR] = dir[bus.port_sel_i];
      d[D_P6]  = s_p6[bus.port_sel_i];
      d[D_P7]  = s_p7[bus.port_sel_i];
      d[D_ONE] = 1'b1;
      d[D_P3]  = s_p3[bus.port_sel_i];
      d[D_P2]  = s_p2[bus.port_sel_i];
      d[D_P4]  = s_p4[bus.port_sel_i];
      d[D_P1]  = s_p1[bus.port_sel_i];
    end
  end
  assign bus.d_o = d;
`ifdef CV_CTRL_QUAD_EN
  step_e step [NUM_PORTS];
  logic [NUM_PORTS-1:0] pend_q, legal, clr;
  logic int_n_q;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
    cv_quad_dec #(.FILT_LEN(FILT_LEN)) u_dec (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (clk_en_3m58_i),
      .a_i       (s_p7[i]),
      .b_i       (s_p9[i]),
      .step_o    (step[i]),
      .dir_o     (dir[i])
    );
    assign legal[i] = step[i] == STEP_FWD || step[i] == STEP_REV;
    assign clr[i]   = bus.rd_i && valid && int'(bus.port_sel_i) == i;
  end
  // A step in the same cycle as the read keeps the port pending
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      pend_q  <= '0;
      int_n_q <= 1'b1;
    end else begin
      pend_q  <= legal | (pend_q & ~clr);
      int_n_q <= ~|pend_q;
    end
  assign bus.int_n_o = int_n_q;
`else
  logic unused_quad;
  assign dir = '0;
  assign bus.int_n_o = 1'b1;
  assign unused_quad = ^{s_p9, bus.rd_i};
`endif
endmodule

// File: tb/tb_cv_ctrl_multi.sv
// tb_cv_ctrl_multi: directed checks of mode select, read mux, latency and spinner decoding
module tb_cv_ctrl_multi;
`ifdef CV_CTRL_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif
  logic clk_i = 1'b0, reset_n_i = 1'b0, clk_en = 1'b0, key_n = 1'b1, joy_n = 1'b1;
  logic [1:0] p1 = '1, p2 = '1, p3 = '1, p4 = '1, p6 = '1, p7 = '1, p9 = '1, p5, p8;
  logic [2:0] p5x, p8x;
  int total = 0, bad = 0;
  always #5 clk_i = ~clk_i;
  cv_ctrl_multi_if #(.NUM_PORTS(2)) bus ();
  cv_ctrl_multi_if #(.NUM_PORTS(3)) bus3 ();
  cv_ctrl_multi #(.NUM_PORTS(2), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_3m58_i(clk_en),
    .ctrl_en_key_n_i(key_n), .ctrl_en_joy_n_i(joy_n),
    .ctrl_p1_i(p1), .ctrl_p2_i(p2), .ctrl_p3_i(p3), .ctrl_p4_i(p4),
    .ctrl_p6_i(p6), .ctrl_p7_i(p7), .ctrl_p9_i(p9),
    .ctrl_p5_o(p5), .ctrl_p8_o(p8), .bus(bus)
  );
  cv_ctrl_multi #(.NUM_PORTS(3), .SYNC_STAGES(2), .FILT_LEN(3)) dut3 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_3m58_i(clk_en),
    .ctrl_en_key_n_i(key_n), .ctrl_en_joy_n_i(joy_n),
    .ctrl_p1_i(3'b111), .ctrl_p2_i(3'b111), .ctrl_p3_i(3'b111), .ctrl_p4_i(3'b111),
    .ctrl_p6_i(3'b111), .ctrl_p7_i(3'b111), .ctrl_p9_i(3'b111),
    .ctrl_p5_o(p5x), .ctrl_p8_o(p8x), .bus(bus3)
  );
  function automatic logic [7:0] ed(logic [7:0] v);
    return QUAD ? v : v & 8'h7F;
  endfunction
  function automatic logic [7:0] ei(logic v);
    return QUAD ? {7'd0, v} : 8'h01;
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic samp(int n);
    clk_en = 1'b1;
    tick(n);
    clk_en = 1'b0;
  endtask
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  initial begin
    bus.port_sel_i = 1'b0; bus.rd_i = 1'b0; bus3.port_sel_i = 2'd3; bus3.rd_i = 1'b0;
    tick(2);
    chk("rst_p5", 8'(p5), 8'h00);
    chk("rst_p8", 8'(p8), 8'h03);
    chk("rst_int", 8'(bus.int_n_o), 8'h01);
    chk("rst_d", bus.d_o, 8'h7F);
    chk("rst_d3_invalid", bus3.d_o, 8'hFF);
    reset_n_i = 1'b1;
    tick(1);
    key_n = 1'b0; joy_n = 1'b1; clk_en = 1'b1; tick(1);
    chk("sel01_p5", 8'(p5), 8'h00);
    chk("sel01_p8", 8'(p8), 8'h03);
    key_n = 1'b1; joy_n = 1'b0; tick(1);
    chk("sel10_p5", 8'(p5), 8'h03);
    chk("sel10_p8", 8'(p8), 8'h00);
    chk("sel10_p5x", 8'(p5x), 8'h07);
    key_n = 1'b0; joy_n = 1'b0; tick(1);
    chk("sel00_hold", 8'(p5), 8'h03);
    key_n = 1'b0; joy_n = 1'b1; clk_en = 1'b0; tick(1);
    chk("sel_no_en", 8'(p5), 8'h03);
    clk_en = 1'b1; tick(1); clk_en = 1'b0; key_n = 1'b1; joy_n = 1'b1;
    chk("sel01_again", 8'(p5), 8'h00);
    bus.port_sel_i = 1'b1; p1 = 2'b01; p3 = 2'b01; p7 = 2'b01;
    tick(1);
    chk("lat_early", bus.d_o, 8'h7F);
    tick(1);
    chk("d_port1_a", bus.d_o, 8'h56);
    p2 = 2'b01; p3 = 2'b11; tick(2);
    chk("d_port1_b", bus.d_o, 8'h5A);
    bus.port_sel_i = 1'b0; #1;
    chk("d_port0", bus.d_o, 8'h7F);
    bus3.port_sel_i = 2'd2; #1;
    chk("d3_port2", bus3.d_o, 8'h7F);
    bus3.port_sel_i = 2'd3; #1;
    chk("d3_port3", bus3.d_o, 8'hFF);
    p1 = '1; p2 = '1; p3 = '1; p7 = '1; tick(2);
    p9 = 2'b10; tick(2); samp(2);
    chk("filt_short", 8'(bus.int_n_o), 8'h01);
    samp(1); tick(1);
    chk("fwd_int", 8'(bus.int_n_o), ei(1'b0));
    chk("fwd_dir", bus.d_o, ed(8'hFF));
    bus.rd_i = 1'b1; tick(1); bus.rd_i = 1'b0; tick(1);
    chk("rd_clr1", 8'(bus.int_n_o), 8'h01);
    p9 = '1; tick(2); samp(3); tick(1);
    chk("rev_int", 8'(bus.int_n_o), ei(1'b0));
    chk("rev_dir", bus.d_o, 8'h7F);
    bus.rd_i = 1'b1; tick(1); bus.rd_i = 1'b0; tick(1);
    chk("rd_clr2", 8'(bus.int_n_o), 8'h01);
    p9 = 2'b10; tick(2); samp(2); p9 = '1; tick(2); samp(3); tick(1);
    chk("glitch_int", 8'(bus.int_n_o), 8'h01);
    chk("glitch_d", bus.d_o, 8'h7F);
    p7 = 2'b10; p9 = 2'b10; tick(2); samp(3); tick(2);
    chk("ill_int", 8'(bus.int_n_o), 8'h01);
    chk("ill_d", bus.d_o, 8'h5F);
    p9 = '1; tick(2); samp(3); tick(1);
    chk("s01_int", 8'(bus.int_n_o), ei(1'b0));
    chk("s01_d", bus.d_o, ed(8'hDF));
    bus.port_sel_i = 1'b1; bus.rd_i = 1'b1; tick(1); bus.rd_i = 1'b0; bus.port_sel_i = 1'b0; tick(1);
    chk("rd_other_port", 8'(bus.int_n_o), ei(1'b0));
    p7 = '1; tick(2); samp(2);
    clk_en = 1'b1; bus.rd_i = 1'b1; tick(1); clk_en = 1'b0; bus.rd_i = 1'b0; tick(1);
    chk("rd_vs_step", 8'(bus.int_n_o), ei(1'b0));
    tick(1);
    chk("rd_vs_step2", 8'(bus.int_n_o), ei(1'b0));
    chk("s11_d", bus.d_o, ed(8'hFF));
    bus.rd_i = 1'b1; tick(1); bus.rd_i = 1'b0; tick(1);
    chk("rd_alone", 8'(bus.int_n_o), 8'h01);
    p9 = 2'b10; tick(2); key_n = 1'b1; joy_n = 1'b0; samp(2); key_n = 1'b1; joy_n = 1'b1;
    chk("pre_rst_p5", 8'(p5), 8'h03);
    reset_n_i = 1'b0; #1;
    chk("mid_rst_p5", 8'(p5), 8'h00);
    chk("mid_rst_p8", 8'(p8), 8'h03);
    chk("mid_rst_int", 8'(bus.int_n_o), 8'h01);
    chk("mid_rst_d", bus.d_o, 8'h7F);
    tick(1); reset_n_i = 1'b1;
    tick(2); samp(1); p9 = '1; tick(2); samp(3); tick(2);
    chk("post_rst_int", 8'(bus.int_n_o), 8'h01);
    chk("post_rst_d", bus.d_o, 8'h7F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
